regs_wr_arb: RTL and testbench
==============================

// Module: regs_wr_arb
// PURPOSE
//  Arbiter and sequencer for the single write port of the picoMIPS register file.
//  - Shares the port between two requesters: A = core writeback, B = host/debug loader.
//  - Drives the file's write enable, destination address and write data from registered outputs.
//  - Filters writes to %0, which is hardwired zero.
//  - Optionally clears every general-purpose register after reset.
// PARAMETERS
//  n     8  data bus width; must match the register file
//  NREG  7  number of writable registers, addresses 1..NREG; address width is fixed at 3
//  DCW   4  width of the dropped-write counter
// PORTS
//  clk        in   1     system clock, rising edge
//  nReset     in   1     asynchronous, active-low reset
//  a_req      in   1     requester A write request
//  a_addr     in   3     requester A destination register
//  a_data     in   n     requester A write data
//  a_gnt      out  1     one-cycle grant pulse to A
//  b_req      in   1     requester B write request
//  b_addr     in   3     requester B destination register
//  b_data     in   n     requester B write data
//  b_gnt      out  1     one-cycle grant pulse to B
//  rf_w       out  1     register file write enable
//  rf_addr    out  3     register file destination address (Raddr2)
//  rf_wdata   out  n     register file write data
//  busy       out  1     high while the init sweep runs; no grants are issued
//  drop_cnt   out  DCW   count of granted writes to %0, saturating
// BEHAVIOUR
//  - Clock and reset: one clock, clk; reset nReset is asynchronous and active-low.
//  - Reset values: all outputs 0; round-robin pointer set to A; FSM to INIT (macro on) or ARB (macro off).
//  - Reset mid-operation aborts any write in progress; the in-flight grant is lost.
//  - Requester protocol: hold req, addr and data stable until the gnt pulse.
//    - Deassert req, or present the next transaction, in the cycle after gnt.
//  - Sampling: in ARB state the arbiter samples requests on edge k.
//    - On edge k+1 exactly one gnt is high for one cycle.
//    - On that same edge rf_w, rf_addr and rf_wdata register the winner's addr and data.
//    - Latency from sampled request to write is 1 cycle.
//  - Re-grant block: a requester whose gnt is high in cycle k is ignored when sampling at the end of cycle k.
//    - Prevents a double grant of a stale request.
//    - A lone requester therefore gets 1 write per 2 cycles.
//    - Alternating A/B requests sustain 1 write per cycle.
//  - Both requesting and eligible: the pointer picks the winner; after any grant the pointer moves to the other requester.
//  - A lone eligible requester always wins, regardless of the pointer.
//  - Address 0: the write is granted (gnt pulses) but rf_w stays 0; drop_cnt increments.
//    - drop_cnt saturates at 2^DCW-1.
//    - %0 must never reach the file: the file indexes register (addr-1).
//  - Address > NREG: treated exactly as address 0.
//  - rf_w is high for exactly one cycle per accepted write; rf_addr and rf_wdata hold their last values otherwise.
//  - FSM states:
//    - INIT: sweep, macro on only; exits to ARB after the write to NREG.
//    - ARB: normal arbitration; self-loop.
// CONFIGURATION
//  Macro REGS_WR_ARB_INIT_CLEAR_EN.
//  - Defined: after reset, INIT writes 0 to addresses 1..NREG, one per cycle, in ascending order.
//    - rf_w is high for NREG cycles.
//    - busy is high from reset release until the cycle after the last sweep write.
//    - Requests seen during INIT are held off, not dropped; they are granted normally in ARB.
//  - Undefined: no INIT state; the FSM resets to ARB; busy is tied 0; register contents after reset are undefined.
// TESTING
//  1. Macro on, release reset -> rf_w high 7 cycles, rf_addr 1..7, rf_wdata 0, busy low after; no gnt during sweep.
//  2. Only A requests addr 3, data 8'h5A, held -> a_gnt and rf_w at k+1 with rf_addr 3, rf_wdata 8'h5A.
//     Next grant to A no earlier than k+3.
//  3. A (addr 1, 8'h11) and B (addr 2, 8'h22) request together, continuously.
//     Writes alternate A,B,A,B one per cycle, starting with A after reset.
//  4. B writes addr 0 three times -> three b_gnt pulses, rf_w stays 0, drop_cnt = 3.
//     With DCW=4 and 20 drops, drop_cnt holds 15.
//  5. Assert nReset low while A is granted mid-stream -> all outputs 0 immediately.
//     Pointer back to A; after release the sweep reruns (macro on).
//  6. Macro off, request at the first cycle after reset -> granted at the next edge; busy stays 0 throughout.

Source files
------------

// File: rtl/regs_wr_arb.sv
// -----------------------------------------------------------------------------
// regs_wr_arb
//
// Arbiter and sequencer for the single write port of the picoMIPS register
// file. Two requesters share the port: A (core writeback) and B (host/debug
// loader). Grants and the file-side write signals all come from registers,
// so the file sees one write one clock after the winning request is sampled.
// Writes to %0, or to an address above NREG, are granted but never reach
// the file. Each one is counted in a saturating drop counter.
//
// Optional feature, macro REGS_WR_ARB_INIT_CLEAR_EN:
//   defined   - after reset an INIT sweep writes 0 to registers 1..NREG,
//               one per cycle, with busy high. Requests wait until the
//               sweep ends.
//   undefined - no sweep; the arbiter starts immediately and busy is tied 0.
//
// Ports
//   clk                    system clock, rising edge
//   nReset                 asynchronous active-low reset
//   a_req/a_addr/a_data    requester A request, destination, data
//   a_gnt                  one-cycle grant pulse to A
//   b_req/b_addr/b_data    requester B request, destination, data
//   b_gnt                  one-cycle grant pulse to B
//   rf_w                   register file write enable
//   rf_addr                register file destination address
//   rf_wdata               register file write data
//   busy                   high while the init sweep runs
//   drop_cnt               saturating count of granted writes to %0/out of range
// -----------------------------------------------------------------------------
module regs_wr_arb #(
   parameter int unsigned n    = 8,
   parameter int unsigned NREG = 7,
   parameter int unsigned DCW  = 4
) (
   input  logic           clk,
   input  logic           nReset,
   input  logic           a_req,
   input  logic [2:0]     a_addr,
   input  logic [n-1:0]   a_data,
   output logic           a_gnt,
   input  logic           b_req,
   input  logic [2:0]     b_addr,
   input  logic [n-1:0]   b_data,
   output logic           b_gnt,
   output logic           rf_w,
   output logic [2:0]     rf_addr,
   output logic [n-1:0]   rf_wdata,
   output logic           busy,
   output logic [DCW-1:0] drop_cnt
);

   typedef enum logic {S_INIT, S_ARB} state_t;

   state_t         state_q, state_d;
   logic           ptr_q, ptr_d;        // 0: A wins a tie, 1: B wins a tie
   logic           a_gnt_q, a_gnt_d;
   logic           b_gnt_q, b_gnt_d;
   logic           rf_w_q, rf_w_d;
   logic [2:0]     rf_addr_q, rf_addr_d;
   logic [n-1:0]   rf_wdata_q, rf_wdata_d;
   logic [DCW-1:0] drop_cnt_q, drop_cnt_d;

`ifdef REGS_WR_ARB_INIT_CLEAR_EN
   localparam logic [2:0] LAST_ADDR = 3'(NREG);
   logic           busy_q, busy_d;
   logic [2:0]     cnt_q, cnt_d;        // next register to clear in the sweep
`endif

   logic           a_elig, b_elig, pick_b;
   logic [2:0]     win_addr;
   logic [n-1:0]   win_data;

   // Only addresses 1..NREG exist in the file; everything else is dropped.
   function automatic logic addr_ok(input logic [2:0] addr);
      return (addr != 3'd0) && (32'(addr) <= NREG);
   endfunction

   // A requester granted this cycle still shows its old request; ignore it
   // so the same transaction is never granted twice.
   assign a_elig   = a_req && !a_gnt_q;
   assign b_elig   = b_req && !b_gnt_q;
   assign pick_b   = b_elig && (!a_elig || ptr_q);
   assign win_addr = pick_b ? b_addr : a_addr;
   assign win_data = pick_b ? b_data : a_data;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      a_gnt_d    = 1'b0;
      b_gnt_d    = 1'b0;
      rf_w_d     = 1'b0;
      rf_addr_d  = rf_addr_q;
      rf_wdata_d = rf_wdata_q;
      drop_cnt_d = drop_cnt_q;
`ifdef REGS_WR_ARB_INIT_CLEAR_EN
      busy_d     = 1'b0;
      cnt_d      = cnt_q;
`endif
      case (state_q)
`ifdef REGS_WR_ARB_INIT_CLEAR_EN
         S_INIT: begin
            // busy stays high through the last sweep write and drops with
            // the first arbitration cycle.
            busy_d     = 1'b1;
            rf_w_d     = 1'b1;
            rf_addr_d  = cnt_q;
            rf_wdata_d = '0;
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q == LAST_ADDR) begin
               state_d = S_ARB;
            end
         end
`endif
         default: begin
            if (a_elig || b_elig) begin
               a_gnt_d = !pick_b;
               b_gnt_d = pick_b;
               ptr_d   = !pick_b;       // the loser of this grant gets priority
               if (addr_ok(win_addr)) begin
                  rf_w_d     = 1'b1;
                  rf_addr_d  = win_addr;
                  rf_wdata_d = win_data;
               end else if (drop_cnt_q != {DCW{1'b1}}) begin
                  drop_cnt_d = drop_cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
`ifdef REGS_WR_ARB_INIT_CLEAR_EN
         state_q <= S_INIT;
         busy_q  <= 1'b0;
         cnt_q   <= 3'd1;
`else
         state_q <= S_ARB;
`endif
         ptr_q      <= 1'b0;
         a_gnt_q    <= 1'b0;
         b_gnt_q    <= 1'b0;
         rf_w_q     <= 1'b0;
         rf_addr_q  <= '0;
         rf_wdata_q <= '0;
         drop_cnt_q <= '0;
      end else begin
`ifdef REGS_WR_ARB_INIT_CLEAR_EN
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
`endif
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         a_gnt_q    <= a_gnt_d;
         b_gnt_q    <= b_gnt_d;
         rf_w_q     <= rf_w_d;
         rf_addr_q  <= rf_addr_d;
         rf_wdata_q <= rf_wdata_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign a_gnt    = a_gnt_q;
   assign b_gnt    = b_gnt_q;
   assign rf_w     = rf_w_q;
   assign rf_addr  = rf_addr_q;
   assign rf_wdata = rf_wdata_q;
   assign drop_cnt = drop_cnt_q;
`ifdef REGS_WR_ARB_INIT_CLEAR_EN
   assign busy     = busy_q;
`else
   assign busy     = 1'b0;
`endif

endmodule

// File: tb/tb_regs_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_regs_wr_arb
//
// Bench for regs_wr_arb. A behavioural model, written in terms of "who may be
// granted, who wins, where the write goes", predicts every output each cycle.
// Directed sequences pin the model with literal values. A random phase then
// drives both requesters under the hold-until-grant protocol.
// -----------------------------------------------------------------------------
module tb_regs_wr_arb;
   localparam int N    = 8;
   localparam int NREG = 7;
   localparam int DCW  = 4;
   localparam int DMAX = (1 << DCW) - 1;

   logic           clk = 1'b0;
   logic           nReset = 1'b1;
   logic           a_req = 1'b0, b_req = 1'b0;
   logic [2:0]     a_addr = '0, b_addr = '0;
   logic [N-1:0]   a_data = '0, b_data = '0;
   logic           a_gnt, b_gnt, rf_w, busy;
   logic [2:0]     rf_addr;
   logic [N-1:0]   rf_wdata;
   logic [DCW-1:0] drop_cnt;

   always #5 clk = ~clk;

   regs_wr_arb #(.n(N), .NREG(NREG), .DCW(DCW)) dut (
      .clk(clk), .nReset(nReset),
      .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
      .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
      .rf_w(rf_w), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
      .busy(busy), .drop_cnt(drop_cnt)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic         m_a_gnt = 0, m_b_gnt = 0, m_rf_w = 0, m_busy = 0;
   logic [2:0]   m_addr = 0;
   logic [N-1:0] m_data = 0;
   int           m_drops = 0;       // every drop, unsaturated
   bit           m_prefer_b = 0;    // who wins a tie next
   int           m_sweep_left = 0;  // sweep writes still to do
   bit           ca, cb, take_b;
   logic [2:0]   wa;

   function automatic bit in_file(input logic [2:0] ad);
      return (ad != 3'd0) && (int'(ad) <= NREG);
   endfunction

   always @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         m_a_gnt = 0; m_b_gnt = 0; m_rf_w = 0; m_busy = 0;
         m_addr = 0; m_data = 0; m_drops = 0; m_prefer_b = 0;
`ifdef REGS_WR_ARB_INIT_CLEAR_EN
         m_sweep_left = NREG;
`else
         m_sweep_left = 0;
`endif
      end else begin
         // a requester granted last cycle is not a candidate now
         ca = a_req && !m_a_gnt;
         cb = b_req && !m_b_gnt;
         m_a_gnt = 0; m_b_gnt = 0; m_rf_w = 0; m_busy = 0;
         if (m_sweep_left > 0) begin
            m_rf_w = 1; m_busy = 1;
            m_addr = 3'(NREG - m_sweep_left + 1);
            m_data = '0;
            m_sweep_left--;
         end else if (ca || cb) begin
            take_b = cb && (!ca || m_prefer_b);
            m_a_gnt = !take_b;
            m_b_gnt = take_b;
            m_prefer_b = !take_b;
            wa = take_b ? b_addr : a_addr;
            if (in_file(wa)) begin
               m_rf_w = 1;
               m_addr = wa;
               m_data = take_b ? b_data : a_data;
            end else begin
               m_drops++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("a_gnt", 32'(a_gnt), 32'(m_a_gnt));
         check("b_gnt", 32'(b_gnt), 32'(m_b_gnt));
         check("rf_w", 32'(rf_w), 32'(m_rf_w));
         check("rf_addr", 32'(rf_addr), 32'(m_addr));
         check("rf_wdata", 32'(rf_wdata), 32'(m_data));
         check("busy", 32'(busy), 32'(m_busy));
         check("drop_cnt", 32'(drop_cnt), 32'((m_drops > DMAX) ? DMAX : m_drops));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_a_gnt"}, 32'(a_gnt), 0);
      check({nm, "_b_gnt"}, 32'(b_gnt), 0);
      check({nm, "_rf_w"}, 32'(rf_w), 0);
      check({nm, "_rf_addr"}, 32'(rf_addr), 0);
      check({nm, "_rf_wdata"}, 32'(rf_wdata), 0);
      check({nm, "_busy"}, 32'(busy), 0);
      check({nm, "_drop_cnt"}, 32'(drop_cnt), 0);
   endtask

   task automatic run_sweep_checks();
`ifdef REGS_WR_ARB_INIT_CLEAR_EN
      for (int i = 1; i <= NREG; i++) begin
         tick();
         check("sweep_rf_w", 32'(rf_w), 1);
         check("sweep_addr", 32'(rf_addr), 32'(i));
         check("sweep_data", 32'(rf_wdata), 0);
         check("sweep_busy", 32'(busy), 1);
         check("sweep_gnt", 32'({a_gnt, b_gnt}), 0);
      end
`endif
   endtask

   int  ngnt;
   bit  a_last, b_last, a_chg, b_chg;

   initial begin
      #2 nReset = 1'b0;
      #1;
      check_all_zero("reset");
      chk_en = 1'b1;

      // A holds addr 3 / 5A from before reset release
      a_req = 1; a_addr = 3'd3; a_data = 8'h5A;
      @(posedge clk); #1 nReset = 1'b1;
      run_sweep_checks();
      tick();
      check("first_a_gnt", 32'(a_gnt), 1);
      check("first_rf_w", 32'(rf_w), 1);
      check("first_addr", 32'(rf_addr), 3);
      check("first_data", 32'(rf_wdata), 32'h5A);
      check("first_busy", 32'(busy), 0);
      tick();
      check("block_a_gnt", 32'(a_gnt), 0);
      check("block_rf_w", 32'(rf_w), 0);
      check("block_hold_addr", 32'(rf_addr), 3);
      tick();
      check("regrant_a_gnt", 32'(a_gnt), 1);
      tick();
      a_req = 0;
      tick();

      // B writes %0: granted, never written, counted
      ngnt = 0;
      b_req = 1; b_addr = 3'd0; b_data = 8'hEE;
      for (int i = 0; i < 40 && ngnt < 3; i++) begin
         tick();
         if (b_gnt) ngnt++;
         check("drop_rf_w", 32'(rf_w), 0);
      end
      b_req = 0;
      check("drop_grants", 32'(ngnt), 3);
      check("drop_cnt3", 32'(drop_cnt), 3);
      tick();
      b_req = 1;
      for (int i = 0; i < 100 && ngnt < 20; i++) begin
         tick();
         if (b_gnt) ngnt++;
      end
      b_req = 0;
      check("drop_grants20", 32'(ngnt), 20);
      check("drop_sat", 32'(drop_cnt), DMAX);
      tick();

      // reset while A is granted
      a_req = 1; a_addr = 3'd4; a_data = 8'h77;
      ngnt = 0;
      for (int i = 0; i < 10 && ngnt == 0; i++) begin
         tick();
         if (a_gnt) ngnt++;
      end
      check("pre_reset_gnt", 32'(a_gnt), 1);
      nReset = 1'b0;
      #1;
      check_all_zero("midreset");

      // both request continuously: A,B,A,B from the reset pointer
      a_req = 1; a_addr = 3'd1; a_data = 8'h11;
      b_req = 1; b_addr = 3'd2; b_data = 8'h22;
      @(posedge clk); #1 nReset = 1'b1;
      run_sweep_checks();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("alt_a_gnt", 32'(a_gnt), 32'((i % 2) == 0));
         check("alt_b_gnt", 32'(b_gnt), 32'((i % 2) == 1));
         check("alt_rf_w", 32'(rf_w), 1);
         check("alt_addr", 32'(rf_addr), ((i % 2) == 0) ? 1 : 2);
         check("alt_data", 32'(rf_wdata), ((i % 2) == 0) ? 32'h11 : 32'h22);
      end
      b_req = 0;
      tick();
      check("alt_tail_a", 32'(a_gnt), 1);
      a_req = 0;
      tick();
      check("idle_rf_w", 32'(rf_w), 0);
      check("idle_hold_addr", 32'(rf_addr), 1);

      // random phase
      a_last = 0; b_last = 0; a_chg = 0; b_chg = 0;
      for (int c = 0; c < 3000; c++) begin
         if (a_chg || !a_req) begin
            a_req  = ($urandom_range(0, 2) != 0);
            a_addr = 3'($urandom_range(0, 7));
            a_data = 8'($urandom);
         end
         if (b_chg || !b_req) begin
            b_req  = ($urandom_range(0, 2) != 0);
            b_addr = 3'($urandom_range(0, 7));
            b_data = 8'($urandom);
         end
         tick();
         a_chg = a_last; a_last = a_gnt;
         b_chg = b_last; b_last = b_gnt;
      end
      a_req = 0; b_req = 0;
      tick();
      tick();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
